// File: rtl/uart_frame_parity_checker.sv
// UART frame receiver: start bit, DATA_WIDTH data bits LSB first, parity, stop.
// Optional saturating parity-error counter enabled by `define PARITY_ERR_COUNT_EN.
module uart_frame_parity_checker #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iBit,
  input  logic                   iBitValid,
  input  logic                   iOddMode,
  input  logic                   iEnable,
  input  logic                   iClearCount,
  output logic [DATA_WIDTH-1:0]  oData,
  output logic                   oDataValid,
  output logic                   oParityError,
  output logic                   oFrameError,
  output logic                   oBusy,
  output logic [COUNT_WIDTH-1:0] oErrCount
);

  localparam int CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    Idle,
    Data,
    Parity,
    Stop
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [CntW-1:0]       bitCount;
  logic                  parityAcc;
  logic                  oddLatched;
  logic                  parityMismatch;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [DATA_WIDTH-1:0] shiftIn;

  logic startFrame;
  logic shiftEn;
  logic captureParity;
  logic captureStop;

  // New bits enter at the MSB so the first bit received ends up at bit 0.
  if (DATA_WIDTH == 1) begin : gNarrow
    assign shiftIn = iBit;
  end else begin : gWide
    assign shiftIn = {iBit, shiftReg[DATA_WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= Idle;
    else       state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    stateNext     = state;
    startFrame    = 1'b0;
    shiftEn       = 1'b0;
    captureParity = 1'b0;
    captureStop   = 1'b0;
    if (!iEnable) begin
      stateNext = Idle;
    end else if (iBitValid) begin
      case (state)
        Idle: begin
          if (!iBit) begin
            startFrame = 1'b1;
            stateNext  = Data;
          end
        end
        Data: begin
          shiftEn = 1'b1;
          if (bitCount == LastBit) stateNext = Parity;
        end
        Parity: begin
          captureParity = 1'b1;
          stateNext     = Stop;
        end
        Stop: begin
          captureStop = 1'b1;
          stateNext   = Idle;
        end
        default: stateNext = Idle;
      endcase
    end
  end

  // NOTE: the shift register is reset along with the control state; it is only
  // DATA_WIDTH flops and keeps X out of oData after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitCount       <= '0;
      parityAcc      <= 1'b0;
      oddLatched     <= 1'b0;
      parityMismatch <= 1'b0;
      shiftReg       <= '0;
      oData          <= '0;
      oDataValid     <= 1'b0;
      oParityError   <= 1'b0;
      oFrameError    <= 1'b0;
      oBusy          <= 1'b0;
    end else begin
      oDataValid <= 1'b0;
      oBusy      <= (stateNext != Idle);
      if (!iEnable) begin
        bitCount  <= '0;
        parityAcc <= 1'b0;
      end else begin
        if (startFrame) begin
          bitCount   <= '0;
          parityAcc  <= 1'b0;
          oddLatched <= iOddMode;
        end
        if (shiftEn) begin
          shiftReg  <= shiftIn;
          parityAcc <= parityAcc ^ iBit;
          bitCount  <= bitCount + CntW'(1);
        end
        if (captureParity) parityMismatch <= (iBit != (parityAcc ^ oddLatched));
        // Frame status is published only when the stop bit completes a frame.
        if (captureStop) begin
          oDataValid   <= 1'b1;
          oData        <= shiftReg;
          oParityError <= parityMismatch;
          oFrameError  <= ~iBit;
        end
      end
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [COUNT_WIDTH-1:0] errCount;

  // Counts during the pulse cycle; a clear in that same cycle takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errCount <= '0;
    end else if (iClearCount) begin
      errCount <= '0;
    end else if (oDataValid && oParityError && (errCount != '1)) begin
      errCount <= errCount + COUNT_WIDTH'(1);
    end
  end

  assign oErrCount = errCount;
`else
  logic unusedClear;

  assign unusedClear = iClearCount;
  assign oErrCount   = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parity_checker.sv
// Self-checking bench for uart_frame_parity_checker: directed frames plus random
// frames checked against a frame-level reference model held in queues.
module tb_uart_frame_parity_checker;

  localparam int DW       = 8;
  localparam int CW       = 2;
  localparam int CountMax = (1 << CW) - 1;
  localparam int FrameLen = DW + 3;
`ifdef PARITY_ERR_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          iBit;
  logic          iBitValid;
  logic          iOddMode;
  logic          iEnable;
  logic          iClearCount;
  logic [DW-1:0] oData;
  logic          oDataValid;
  logic          oParityError;
  logic          oFrameError;
  logic          oBusy;
  logic [CW-1:0] oErrCount;

  typedef struct {
    logic [DW-1:0] data;
    logic          pErr;
    logic          fErr;
    int            cyc;
  } frameT;

  frameT expQ[$];
  frameT gotQ[$];
  int    cyc      = 0;
  int    nChecks  = 0;
  int    nFail    = 0;
  int    errModel = 0;

  uart_frame_parity_checker #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iBit        (iBit),
    .iBitValid   (iBitValid),
    .iOddMode    (iOddMode),
    .iEnable     (iEnable),
    .iClearCount (iClearCount),
    .oData       (oData),
    .oDataValid  (oDataValid),
    .oParityError(oParityError),
    .oFrameError (oFrameError),
    .oBusy       (oBusy),
    .oErrCount   (oErrCount)
  );

  always #5 clk = ~clk;

  // Record every valid pulse with the cycle it was seen in.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (oDataValid) gotQ.push_back('{oData, oParityError, oFrameError, cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input logic b, input logic en = 1'b1);
    @(negedge clk);
    iBit      = b;
    iBitValid = 1'b1;
    iEnable   = en;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iBit      = 1'b1;
      iBitValid = 1'b0;
      iEnable   = 1'b1;
    end
  endtask

  // Sends one full frame; flip inverts the correct parity bit.
  task automatic sendFrame(input logic [DW-1:0] data, input logic odd, input logic flip,
                           input logic stopBit, input int gapMax = 0);
    logic parityBit;
    parityBit = (^data) ^ odd ^ flip;
    driveBit(1'b0);
    iOddMode = odd;
    for (int i = 0; i < DW; i++) begin
      if (gapMax > 0) idle($urandom_range(0, gapMax));
      driveBit(data[i]);
      iOddMode = ~odd;
    end
    if (gapMax > 0) idle($urandom_range(0, gapMax));
    driveBit(parityBit);
    if (gapMax > 0) idle($urandom_range(0, gapMax));
    driveBit(stopBit);
    expQ.push_back('{data, flip, ~stopBit, 0});
  endtask

  task automatic compareFrames(input string tag);
    idle(3);
    check({tag, "_pulses"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < gotQ.size()) begin
        check({tag, "_data"}, gotQ[i].data, expQ[i].data);
        check({tag, "_perr"}, gotQ[i].pErr, expQ[i].pErr);
        check({tag, "_ferr"}, gotQ[i].fErr, expQ[i].fErr);
      end
      if (expQ[i].pErr && errModel < CountMax) errModel++;
    end
    check({tag, "_errcnt"}, oErrCount, CountEn ? errModel : 0);
    check({tag, "_idle"}, oBusy, 0);
    expQ.delete();
    gotQ.delete();
  endtask

  initial begin
    reset       = 1'b1;
    iBit        = 1'b1;
    iBitValid   = 1'b0;
    iOddMode    = 1'b0;
    iEnable     = 1'b1;
    iClearCount = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", oData, 0);
    check("rst_valid", oDataValid, 0);
    check("rst_perr", oParityError, 0);
    check("rst_ferr", oFrameError, 0);
    check("rst_busy", oBusy, 0);
    check("rst_errcnt", oErrCount, 0);
    reset = 1'b0;
    idle(2);

    // Idle-line ones are ignored.
    repeat (4) driveBit(1'b1);
    idle(1);
    check("idle_ones_busy", oBusy, 0);

    // Clean even frame with explicit latency and busy checks.
    sendFrame(8'hA5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    iBitValid = 1'b0;
    check("a5_latency", oDataValid, 1);
    @(negedge clk);
    check("a5_pulse_width", oDataValid, 0);
    compareFrames("a5");
    check("a5_hold", oData, 8'hA5);

    // Even mode, wrong parity bit.
    sendFrame(8'h07, 1'b0, 1'b1, 1'b1);
    compareFrames("07_perr");

    // Odd mode, stop bit low.
    sendFrame(8'h00, 1'b1, 1'b0, 1'b0);
    compareFrames("00_ferr");

    // Abort after the 4th data bit, then a complete frame.
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(i[0]);
    check("abort_busy_before", oBusy, 1);
    @(negedge clk);
    iEnable   = 1'b0;
    iBitValid = 1'b1;
    iBit      = 1'b0;
    @(negedge clk);
    check("abort_busy_after", oBusy, 0);
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b1);
    compareFrames("abort_3c");

    // Back-to-back frames with no gap: next start bit follows the stop bit.
    sendFrame(8'h11, 1'b0, 1'b0, 1'b1);
    sendFrame(8'hEE, 1'b1, 1'b0, 1'b1);
    idle(3);
    if (gotQ.size() == 2) check("b2b_spacing", gotQ[1].cyc - gotQ[0].cyc, FrameLen);
    compareFrames("b2b");

    // Strobe every cycle with an idle-one gap of one frame length.
    sendFrame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (FrameLen) driveBit(1'b1);
    sendFrame(8'hEE, 1'b0, 1'b0, 1'b1);
    idle(3);
    if (gotQ.size() == 2) check("gap_spacing", gotQ[1].cyc - gotQ[0].cyc, 2 * FrameLen);
    compareFrames("gap");

    // Random frames with random strobe gaps and idle ones.
    for (int blk = 0; blk < 3; blk++) begin
      for (int f = 0; f < 8; f++) begin
        repeat ($urandom_range(0, 2)) driveBit(1'b1);
        sendFrame(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 2);
      end
      compareFrames("rand");
    end

    // Standalone clear, then saturation.
    @(negedge clk);
    iClearCount = 1'b1;
    @(negedge clk);
    iClearCount = 1'b0;
    errModel    = 0;
    check("clear_alone", oErrCount, 0);
    for (int f = 0; f < 5; f++) begin
      sendFrame(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      compareFrames("sat");
    end
    check("sat_value", oErrCount, CountEn ? CountMax : 0);

    // Clear in the same cycle as a parity-error pulse wins over the increment.
    sendFrame(8'h5A, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    iBitValid   = 1'b0;
    iClearCount = 1'b1;
    check("clr_pulse_align", oDataValid, 1);
    @(negedge clk);
    iClearCount = 1'b0;
    idle(2);
    check("clr_wins", oErrCount, 0);
    check("clr_pulses", gotQ.size(), 1);
    expQ.delete();
    gotQ.delete();
    errModel = 0;

    // Reset mid-frame returns to reset values without waiting for a clock.
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b1);
    @(negedge clk);
    iBitValid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", oBusy, 0);
    check("midrst_data", oData, 0);
    check("midrst_perr", oParityError, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("midrst_nopulse", gotQ.size(), 0);
    gotQ.delete();
    sendFrame(8'hC3, 1'b1, 1'b0, 1'b1);
    compareFrames("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
